// File: rtl/instr_exec_pkg.sv
// Shared types and constants for the instr_exec register-register sequencer.
// Instruction layout: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [8:0] imm9.
package instr_exec_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned IMM_W      = 9;
  localparam int unsigned SHAMT_W    = 4;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RA_LSB  = 6;
  localparam int unsigned RB_LSB  = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MOV = 4'd7,
    OP_LDI = 4'd8,
    OP_NOP = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam logic [INSTR_W-1:0] INSTR_NOP = {OP_NOP, 12'h000};

  // Arithmetic, logic and shift ops (opcodes 0..6) are the ones that update flags.
  function automatic logic op_sets_flags(input logic [OP_W-1:0] op);
    return (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for instr_exec: decodes the opcode, produces the result,
// the carry/borrow bit and the write/illegal qualifiers.
module exec_alu
  import instr_exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm9,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              writes,
  output logic              illegal
);

  logic [DATA_W:0] wide;

  // One extra bit so ADD carry-out and SUB borrow fall out of the same sum.
  always_comb begin
    wide    = '0;
    writes  = 1'b1;
    illegal = 1'b0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_SHL:  wide = {1'b0, a << b[SHAMT_W-1:0]};
      OP_SHR:  wide = {1'b0, a >> b[SHAMT_W-1:0]};
      OP_MOV:  wide = {1'b0, a};
      OP_LDI:  wide = (DATA_W+1)'(imm9);
      OP_NOP:  writes = 1'b0;
      default: begin
        writes  = 1'b0;
        illegal = 1'b1;
      end
    endcase
    result = wide[DATA_W-1:0];
    carry  = wide[DATA_W];
  end

endmodule

// File: rtl/instr_exec.sv
// Execute/writeback sequencer in front of the 8x16 register file (IDLE -> EXEC -> WB).
// Optional flag outputs flag_z/flag_n/flag_c when INSTR_EXEC_FLAGS_EN is defined.
module instr_exec
  import instr_exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  rd_addr_a,
  output logic [ADDR_W-1:0]  rd_addr_b,
  input  logic [DATA_W-1:0]  d_out_a,
  input  logic [DATA_W-1:0]  d_out_b,
  output logic               wr,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  d_in,
  output logic               busy,
  output logic               done,
  output logic               illegal
`ifdef INSTR_EXEC_FLAGS_EN
  ,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_c
`endif
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    rd_addr_a_d, rd_addr_b_d, wr_addr_d;
  logic [DATA_W-1:0]    d_in_d;
  logic                 wr_d, done_d, illegal_d, ready_d, busy_d;

  logic [OP_W-1:0]      op_q;
  logic [ADDR_W-1:0]    rd_q;
  logic [IMM_W-1:0]     imm_q;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_carry, alu_writes, alu_illegal;

  assign op_q  = instr_q[OP_LSB +: OP_W];
  assign rd_q  = instr_q[RD_LSB +: ADDR_W];
  assign imm_q = instr_q[IMM_LSB +: IMM_W];

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op_q),
    .a       (d_out_a),
    .b       (d_out_b),
    .imm9    (imm_q),
    .result  (alu_result),
    .carry   (alu_carry),
    .writes  (alu_writes),
    .illegal (alu_illegal)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rd_addr_a_d = rd_addr_a;
    rd_addr_b_d = rd_addr_b;
    wr_addr_d   = wr_addr;
    d_in_d      = d_in;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d     = S_EXEC;
          instr_d     = instr;
          rd_addr_a_d = instr[RA_LSB +: ADDR_W];
          rd_addr_b_d = instr[RB_LSB +: ADDR_W];
        end
      end
      S_EXEC: begin
        state_d   = S_WB;
        wr_d      = alu_writes;
        done_d    = 1'b1;
        illegal_d = alu_illegal;
        if (alu_writes) begin
          wr_addr_d = rd_q;
          d_in_d    = alu_result;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      instr_q     <= INSTR_NOP;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      wr          <= 1'b0;
      wr_addr     <= '0;
      d_in        <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rd_addr_a   <= rd_addr_a_d;
      rd_addr_b   <= rd_addr_b_d;
      wr          <= wr_d;
      wr_addr     <= wr_addr_d;
      d_in        <= d_in_d;
      done        <= done_d;
      illegal     <= illegal_d;
      instr_ready <= ready_d;
      busy        <= busy_d;
    end
  end

`ifdef INSTR_EXEC_FLAGS_EN
  logic carry_q, flag_upd_q;

  // Flags derive from the WB-cycle result so they commit together with the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q    <= 1'b0;
      flag_upd_q <= 1'b0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
    end else begin
      if (state_q == S_EXEC) begin
        carry_q    <= alu_carry && (op_q <= OP_SUB);
        flag_upd_q <= op_sets_flags(op_q);
      end
      if (state_q == S_WB && flag_upd_q) begin
        flag_z <= (d_in == '0);
        flag_n <= d_in[DATA_W-1];
        flag_c <= carry_q;
      end
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

endmodule

// File: tb/tb_instr_exec.sv
// Scoreboard bench for instr_exec with a behavioural 8x16 register file.
// Define INSTR_EXEC_FLAGS_EN to also check the flag outputs.
module tb_instr_exec;

  typedef struct {
    logic        wr;
    logic        ill;
    logic        fupd;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        z, n, c;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready, wr, busy, done, illegal;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_out_a, d_out_b, d_in;
`ifdef INSTR_EXEC_FLAGS_EN
  logic        flag_z, flag_n, flag_c;
  logic        f_pend = 1'b0;
  logic        f_z, f_n, f_c;
`endif

  logic [15:0] rf [8];
  logic [15:0] gold [8];
  logic        g_z = 1'b0, g_n = 1'b0, g_c = 1'b0;
  logic        bd_en = 1'b0;
  logic [2:0]  bd_addr = 3'd0;
  logic [15:0] bd_data = 16'h0000;
  exp_t        exp_q[$];
  int          cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: combinational read, write at the end of the WB cycle.
  always @(posedge clk) begin
    if (wr) rf[wr_addr] <= d_in;
    else if (bd_en) rf[bd_addr] <= bd_data;
  end
  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];

  instr_exec dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .d_out_a     (d_out_a),
    .d_out_b     (d_out_b),
    .wr          (wr),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
`ifdef INSTR_EXEC_FLAGS_EN
    ,
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_c      (flag_c)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'h8, rd, imm};
  endfunction

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    logic [15:0] a, b;
    a = gold[ins[8:6]];
    b = gold[ins[5:3]];
    e.wr = 1'b1; e.ill = 1'b0; e.fupd = 1'b1; e.c = 1'b0;
    e.addr = ins[11:9]; e.data = 16'h0000; e.z = 1'b0; e.n = 1'b0; e.acc = 0;
    case (ins[15:12])
      4'h0: begin e.data = a + b; e.c = (32'(a) + 32'(b)) > 32'h0000_FFFF; end
      4'h1: begin e.data = a - b; e.c = (a < b); end
      4'h2: e.data = a & b;
      4'h3: e.data = a | b;
      4'h4: e.data = a ^ b;
      4'h5: e.data = a << b[3:0];
      4'h6: e.data = a >> b[3:0];
      4'h7: begin e.data = a; e.fupd = 1'b0; end
      4'h8: begin e.data = {7'd0, ins[8:0]}; e.fupd = 1'b0; end
      4'hF: begin e.wr = 1'b0; e.fupd = 1'b0; end
      default: begin e.wr = 1'b0; e.ill = 1'b1; e.fupd = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic push(input logic [15:0] ins);
    exp_t e;
    e = model(ins);
    e.acc = cyc;
    if (e.wr) gold[e.addr] = e.data;
    if (e.fupd) begin g_z = (e.data == 16'h0000); g_n = e.data[15]; g_c = e.c; end
    e.z = g_z; e.n = g_n; e.c = g_c;
    exp_q.push_back(e);
  endtask

  // Advance to the next falling edge and run the output monitor there.
  task automatic step();
    exp_t e;
    @(negedge clk);
`ifdef INSTR_EXEC_FLAGS_EN
    if (f_pend) begin
      check("flag_z", flag_z, f_z);
      check("flag_n", flag_n, f_n);
      check("flag_c", flag_c, f_c);
      f_pend = 1'b0;
    end
`endif
    if (done) begin
      if (exp_q.size() == 0) check("sb_underflow", done, 0);
      else begin
        e = exp_q.pop_front();
        check("latency", 32'(cyc - e.acc), 2);
        check("wr", wr, e.wr);
        check("illegal", illegal, e.ill);
        if (e.wr) begin
          check("wr_addr", wr_addr, e.addr);
          check("d_in", d_in, e.data);
        end
`ifdef INSTR_EXEC_FLAGS_EN
        f_pend = 1'b1; f_z = e.z; f_n = e.n; f_c = e.c;
`endif
      end
    end else check("no_pulse", {wr, illegal}, 2'b00);
  endtask

  task automatic issue(input logic [15:0] ins);
    int n = 0;
    step();
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin step(); n++; end
    check("accept_timeout", instr_ready, 1);
    push(ins);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin step(); n++; end
    check("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  task automatic set_reg(input logic [2:0] i, input logic [15:0] v);
    step();
    bd_en = 1'b1; bd_addr = i; bd_data = v;
    @(posedge clk);
    #1 bd_en = 1'b0;
    gold[i] = v;
  endtask

  task automatic check_rf();
    for (int i = 0; i < 8; i++) check($sformatf("rf%0d", i), rf[i], gold[i]);
  endtask

  task automatic check_idle_reset_state();
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wr", wr, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_d_in", d_in, 0);
    check("rst_rd_addr", {rd_addr_a, rd_addr_b}, 6'd0);
`ifdef INSTR_EXEC_FLAGS_EN
    check("rst_flags", {flag_z, flag_n, flag_c}, 3'b000);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] saved [8];
    int accs, first_k, second_k;

    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'h0000);
    step();
    check_idle_reset_state();
    reset = 1'b1;

    // LDI immediates then ADD, with operand addresses held afterwards.
    issue(ldi(3'd1, 9'h1FF)); drain();
    issue(ldi(3'd2, 9'h002)); drain();
    issue(enc(4'h0, 3'd3, 3'd1, 3'd2)); drain();
    check("add_r3", rf[3], 16'h0201);
    check("rd_hold", {rd_addr_a, rd_addr_b}, {3'd1, 3'd2});

    // ADD wraps to zero with carry.
    set_reg(3'd1, 16'hFFFF); set_reg(3'd2, 16'h0001);
    issue(enc(4'h0, 3'd4, 3'd1, 3'd2)); drain();
    check("add_wrap", rf[4], 16'h0000);
`ifdef INSTR_EXEC_FLAGS_EN
    check("add_zcn", {flag_z, flag_c, flag_n}, 3'b110);
`endif

    // SUB borrow.
    set_reg(3'd1, 16'h0000);
    issue(enc(4'h1, 3'd5, 3'd1, 3'd2)); drain();
    check("sub_borrow", rf[5], 16'hFFFF);
`ifdef INSTR_EXEC_FLAGS_EN
    check("sub_zcn", {flag_z, flag_c, flag_n}, 3'b011);
`endif

    // Shifts, including ra==rb.
    set_reg(3'd1, 16'h8001); set_reg(3'd2, 16'h0004);
    issue(enc(4'h6, 3'd6, 3'd1, 3'd2)); drain();
    check("shr", rf[6], 16'h0800);
    issue(enc(4'h5, 3'd7, 3'd1, 3'd1)); drain();
    check("shl_self", rf[7], 16'h0002);

    // Logic ops, MOV/LDI leave flags alone, NOP, rd aliasing an operand.
    issue(enc(4'h2, 3'd0, 3'd6, 3'd1)); drain();
    issue(enc(4'h3, 3'd0, 3'd6, 3'd1)); drain();
    issue(enc(4'h4, 3'd5, 3'd5, 3'd1)); drain();
    issue(enc(4'h7, 3'd3, 3'd5, 3'd0)); drain();
    issue(ldi(3'd4, 9'h000)); drain();
    issue(enc(4'hF, 3'd2, 3'd1, 3'd1)); drain();
    issue(enc(4'h0, 3'd1, 3'd1, 3'd1)); drain();
    check("add_self", rf[1], 16'h0002);
    check_rf();

    // Illegal opcode with instr_valid held for six cycles.
    step();
    instr = {4'hA, 3'd3, 3'd1, 3'd2, 3'b000};
    instr_valid = 1'b1;
    accs = 0; first_k = -1; second_k = -1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      check("ill_ready", instr_ready, (k == 0 || k == 3) ? 1 : 0);
      if (instr_ready) begin
        push(instr);
        if (accs == 0) first_k = k; else second_k = k;
        accs++;
      end
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    drain();
    check("ill_accepts", accs, 2);
    check("ill_gap", 32'(second_k - first_k), 3);
    check_rf();

    // Random instruction mix against the model.
    for (int i = 0; i < 24; i++) begin
      issue(16'($urandom));
      drain();
    end
    check_rf();

    // Reset asserted in the middle of an ADD's WB cycle.
    set_reg(3'd0, 16'h0000); set_reg(3'd6, 16'h0001); set_reg(3'd7, 16'h0002);
    for (int i = 0; i < 8; i++) saved[i] = gold[i];
    issue(enc(4'h0, 3'd0, 3'd6, 3'd7));
    step();
    @(posedge clk);
    #3;
    check("pre_rst_wr", wr, 1);
    reset = 1'b0;
    #1;
    check_idle_reset_state();
    exp_q.delete();
    for (int i = 0; i < 8; i++) gold[i] = saved[i];
    g_z = 1'b0; g_n = 1'b0; g_c = 1'b0;
    step();
    step();
    check_rf();
    reset = 1'b1;

    // Recovery after reset.
    issue(enc(4'h0, 3'd2, 3'd6, 3'd7)); drain();
    check("post_rst_add", rf[2], 16'h0003);
    check_rf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
